// File: rtl/fan_ctrl_sched.sv
// Smart-fan controller: target selection, duty slewing, kick-start, stall trip, telemetry.
// Optional FAN_AUTO_HYST_EN adds a 2 degC hysteresis on the auto-curve temperature.
module fan_ctrl_sched #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RAMP_CYC   = 50_000,
    parameter int KICK_CYC   = 25_000_000,
    parameter int STALL_SEC  = 3,
    parameter int T_LOW      = 30,
    parameter int T_HIGH     = 70,
    parameter int DUTY_SLOPE = 6,
    parameter int DUTY_MIN   = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    input  logic [12:0] cmd_data,
    input  logic [7:0]  temp_data,
    input  logic [15:0] rpm,
    output logic [7:0]  duty,
    output logic        fault,
    output logic        tele_req,
    input  logic        tele_ack,
    output logic [23:0] tele_data
);

    localparam int TW = $clog2(CLK_FREQ);
    localparam int KW = $clog2(KICK_CYC + 1);
    localparam int RW = $clog2(RAMP_CYC + 1);
    localparam int SW = $clog2(STALL_SEC + 1);

    typedef enum logic [2:0] {
        IDLE, KICK, RAMP, RUN, FLT
    } state_t;

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [7:0]     setpt_q, setpt_d;
    logic [7:0]     duty_q, duty_d;
    logic           fault_q, fault_d;
    logic           req_q, req_d;
    logic [23:0]    tdata_q, tdata_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [KW-1:0]  kick_cnt_q, kick_cnt_d;
    logic [RW-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [SW-1:0]  stall_cnt_q, stall_cnt_d;

    logic           tick;
    logic [7:0]     temp_use;
    logic [15:0]    prod;
    logic [7:0]     raw;
    logic [7:0]     target;
    logic           unused_bits;

    assign unused_bits = ^cmd_data[3:0];
    assign tick = (tick_cnt_q == TW'(CLK_FREQ - 1));

`ifdef FAN_AUTO_HYST_EN
    logic [7:0] teff_q, teff_d;
    logic [7:0] tdiff;

    assign tdiff = (temp_data >= teff_q) ? temp_data - teff_q
                                         : teff_q - temp_data;
    assign temp_use = teff_q;

    // Entering auto mode snaps to the live temperature.
    always_comb begin
        teff_d = teff_q;
        if (cmd_valid && !cmd_data[12] && mode_q)
            teff_d = temp_data;
        else if (tdiff >= 8'd2)
            teff_d = temp_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) teff_q <= '0;
        else         teff_q <= teff_d;
    end
`else
    assign temp_use = temp_data;
`endif

    always_comb begin
        prod = 16'(temp_use - 8'(T_LOW)) * 16'(DUTY_SLOPE);
        raw  = '0;
        if (mode_q)
            raw = setpt_q;
        else if (temp_use < 8'(T_LOW))
            raw = '0;
        else if (temp_use >= 8'(T_HIGH))
            raw = 8'hFF;
        else if (prod > 16'd255)
            raw = 8'hFF;
        else
            raw = prod[7:0];
        if (raw == 8'd0)
            target = '0;
        else if (raw < 8'(DUTY_MIN))
            target = 8'(DUTY_MIN);
        else
            target = raw;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        setpt_d     = setpt_q;
        duty_d      = duty_q;
        fault_d     = fault_q;
        req_d       = req_q;
        tdata_d     = tdata_q;
        kick_cnt_d  = kick_cnt_q;
        ramp_cnt_d  = ramp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);

        if (cmd_valid) begin
            mode_d  = cmd_data[12];
            setpt_d = cmd_data[11:4];
        end

        // An ack completing a frame wins over a coincident tick.
        if (req_q) begin
            if (tele_ack) req_d = 1'b0;
        end else if (tick) begin
            req_d   = 1'b1;
            tdata_d = {duty_q, rpm};
        end

        if (state_q == RAMP || state_q == RUN) begin
            if (tick && duty_q != 8'd0)
                stall_cnt_d = (rpm == 16'd0) ? stall_cnt_q + SW'(1) : '0;
        end else begin
            stall_cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                duty_d = '0;
                if (target != 8'd0) begin
                    state_d    = KICK;
                    duty_d     = 8'hFF;
                    kick_cnt_d = '0;
                end
            end
            KICK: begin
                duty_d = 8'hFF;
                if (target == 8'd0 || kick_cnt_q == KW'(KICK_CYC - 1)) begin
                    state_d    = RAMP;
                    kick_cnt_d = '0;
                    ramp_cnt_d = '0;
                end else begin
                    kick_cnt_d = kick_cnt_q + KW'(1);
                end
            end
            RAMP: begin
                if (duty_q == target) begin
                    state_d    = (target == 8'd0) ? IDLE : RUN;
                    ramp_cnt_d = '0;
                end else if (ramp_cnt_q == RW'(RAMP_CYC - 1)) begin
                    ramp_cnt_d = '0;
                    duty_d     = (duty_q < target) ? duty_q + 8'd1
                                                   : duty_q - 8'd1;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + RW'(1);
                end
            end
            RUN: begin
                if (target != duty_q) begin
                    state_d    = RAMP;
                    ramp_cnt_d = '0;
                end
            end
            FLT: begin
                duty_d  = '0;
                fault_d = 1'b1;
                if (cmd_valid) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall trip overrides everything, including a coincident command.
        if (stall_cnt_d == SW'(STALL_SEC)) begin
            state_d     = FLT;
            duty_d      = '0;
            fault_d     = 1'b1;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            setpt_q     <= '0;
            duty_q      <= '0;
            fault_q     <= 1'b0;
            req_q       <= 1'b0;
            tdata_q     <= '0;
            tick_cnt_q  <= '0;
            kick_cnt_q  <= '0;
            ramp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            setpt_q     <= setpt_d;
            duty_q      <= duty_d;
            fault_q     <= fault_d;
            req_q       <= req_d;
            tdata_q     <= tdata_d;
            tick_cnt_q  <= tick_cnt_d;
            kick_cnt_q  <= kick_cnt_d;
            ramp_cnt_q  <= ramp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign duty      = duty_q;
    assign fault     = fault_q;
    assign tele_req  = req_q;
    assign tele_data = tdata_q;

endmodule
